// File: rtl/slice_remap_pkg.sv
// Shared constants, types and helpers for the slice remap pipeline.
// Map tables are handled as flattened vectors so one helper serves any NSEG/IDXW.
package slice_remap_pkg;

    localparam int DEFAULT_WIDTH = 128;
    localparam int DEFAULT_SEG   = 8;
    localparam int DEFAULT_DEPTH = 2;

    // Upper bounds for the flattened identity table (256 segments of 8-bit index).
    localparam int MAX_IDXW     = 8;
    localparam int MAX_NSEG     = 256;
    localparam int MAX_MAP_BITS = MAX_NSEG * MAX_IDXW;

    typedef struct packed {
        logic [MAX_IDXW-1:0] idx;
        logic [MAX_IDXW-1:0] src;
    } cfg_write_t;

    function automatic int seg_count(input int width, input int seg);
        return width / seg;
    endfunction

    function automatic logic [MAX_MAP_BITS-1:0] identity_map(input int nseg, input int idxw);
        logic [MAX_MAP_BITS-1:0] mapBits;
        mapBits = '0;
        for (int i = 0; i < nseg; i++) begin
            for (int b = 0; b < idxw; b++) begin
                mapBits[i*idxw + b] = i[b];
            end
        end
        return mapBits;
    endfunction

endpackage

// File: rtl/slice_remap_stage.sv
// One valid/data slot of the remap pipeline; reloads whenever it is empty
// or its current word leaves in the same cycle, so bubbles collapse.
module slice_remap_stage
    import slice_remap_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inValid,
    input  logic [WIDTH-1:0] i_inData,
    input  logic             i_downReady,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             w_load;

    assign w_load  = ~r_valid | i_downReady;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_load) begin
            r_valid <= i_inValid;
            if (i_inValid) begin
                r_data <= i_inData;
            end
        end
    end

endmodule

// File: rtl/slice_remap_pipe.sv
// Pipelined segment remapper: out segment i takes in segment map[i] at stage-0 entry,
// with a reprogrammable map table that only accepts writes while the pipeline is empty.
module slice_remap_pipe
    import slice_remap_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int SEG   = DEFAULT_SEG,
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int NSEG  = seg_count(WIDTH, SEG),
    localparam int IDXW  = (NSEG > 1) ? $clog2(NSEG) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             cfg_we,
    output logic             cfg_ready,
    input  logic [IDXW-1:0]  cfg_idx,
    input  logic [IDXW-1:0]  cfg_src,
    output logic             map_identity,
    output logic [31:0]      xfer_count
);

    localparam logic [MAX_MAP_BITS-1:0] IDENT_FULL = identity_map(NSEG, IDXW);
    localparam logic [NSEG*IDXW-1:0]    IDENT_MAP  = IDENT_FULL[NSEG*IDXW-1:0];

    logic [IDXW-1:0]  r_map [NSEG];
    logic             r_mapIdentity;
    logic [31:0]      r_xferCount;

    cfg_write_t       w_cfgWrite;
    logic             w_cfgAccept;
    logic             w_cfgInRange;
    logic             w_isIdentity;
    logic [SEG-1:0]   w_inSeg [NSEG];
    logic [WIDTH-1:0] w_remapped;
    logic [DEPTH-1:0] w_stageValid;
    logic [WIDTH-1:0] w_stageData [DEPTH];
    logic [DEPTH:0]   w_stageReady;

    assign cfg_ready    = ~|w_stageValid;
    assign w_cfgAccept  = cfg_we & cfg_ready;
    assign w_cfgWrite   = '{idx: MAX_IDXW'(cfg_idx), src: MAX_IDXW'(cfg_src)};
    assign w_cfgInRange = (int'(w_cfgWrite.idx) < NSEG) && (int'(w_cfgWrite.src) < NSEG);

    assign in_ready     = w_stageReady[0] & ~w_cfgAccept;
    assign out_valid    = w_stageValid[DEPTH-1];
    assign out_data     = w_stageData[DEPTH-1];
    assign map_identity = r_mapIdentity;
    assign xfer_count   = r_xferCount;

    // Ready of stage k unrolled as "some slot at or after k is free, or the sink takes a word".
    assign w_stageReady[DEPTH] = out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_ready
        assign w_stageReady[k] = out_ready | ~(&w_stageValid[DEPTH-1:k]);
    end

    for (genvar g = 0; g < NSEG; g++) begin : g_remap
        assign w_inSeg[g]               = in_data[g*SEG +: SEG];
        assign w_remapped[g*SEG +: SEG] = w_inSeg[r_map[g]];
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_first
            slice_remap_stage #(.WIDTH(WIDTH)) u_stage (
                .clk         (clk),
                .reset       (reset),
                .i_inValid   (in_valid & ~w_cfgAccept),
                .i_inData    (w_remapped),
                .i_downReady (w_stageReady[k+1]),
                .o_valid     (w_stageValid[k]),
                .o_data      (w_stageData[k])
            );
        end else begin : g_rest
            slice_remap_stage #(.WIDTH(WIDTH)) u_stage (
                .clk         (clk),
                .reset       (reset),
                .i_inValid   (w_stageValid[k-1]),
                .i_inData    (w_stageData[k-1]),
                .i_downReady (w_stageReady[k+1]),
                .o_valid     (w_stageValid[k]),
                .o_data      (w_stageData[k])
            );
        end
    end

    always_comb begin
        w_isIdentity = 1'b1;
        for (int i = 0; i < NSEG; i++) begin
            if (r_map[i] != IDENT_MAP[i*IDXW +: IDXW]) begin
                w_isIdentity = 1'b0;
            end
        end
    end

    // Out-of-range writes are still handshaked but leave the table untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NSEG; i++) begin
                r_map[i] <= IDENT_MAP[i*IDXW +: IDXW];
            end
            r_mapIdentity <= 1'b1;
            r_xferCount   <= 32'd0;
        end else begin
            if (w_cfgAccept && w_cfgInRange) begin
                r_map[w_cfgWrite.idx[IDXW-1:0]] <= w_cfgWrite.src[IDXW-1:0];
            end
            r_mapIdentity <= w_isIdentity;
            if (out_valid && out_ready) begin
                r_xferCount <= r_xferCount + 32'd1;
            end
        end
    end

endmodule
